subbytes_engine: RTL
====================

SUBBYTES_ENGINE -- requirements
Module: subbytes_engine

Interface
REQ-001 SHALL provide parameter LANES, default 4: number of byte lanes processed per beat; legal range 1..16.
REQ-002 SHALL provide parameter INV_EN, default 1: 1 = inverse S-box selectable per beat; 0 = forward only.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-005 SHALL provide port in_valid, input, 1 bit: upstream beat present.
REQ-006 SHALL provide port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-007 SHALL provide port in_inv, input, 1 bit: per-beat mode; 1 = inverse S-box, 0 = forward S-box.
REQ-008 SHALL provide port in_data, input, 8*LANES bits: lane i occupies bits [8i+7:8i].
REQ-009 SHALL provide port out_valid, output, 1 bit: result beat present.
REQ-010 SHALL provide port out_ready, input, 1 bit: downstream accepts the result beat.
REQ-011 SHALL provide port out_inv, output, 1 bit: mode bit that travelled with the beat.
REQ-012 SHALL provide port out_data, output, 8*LANES bits: substituted bytes, same lane mapping as in_data.
REQ-013 SHALL provide port beat_cnt, output, 16 bits: count of beats delivered on the output.

Function
REQ-014 SHALL map each lane independently: forward = FIPS-197 S-box; inverse = FIPS-197 inverse S-box.
REQ-015 SHALL, when INV_EN=0, ignore in_inv, use forward for every beat, and drive out_inv as 0.
REQ-016 SHALL pass every beat through a 2-stage register pipeline: S1 captures in_data and in_inv; S2 captures the lookup result.
REQ-017 SHALL define an input transfer as in_valid & in_ready, and an output transfer as out_valid & out_ready, both sampled at the clock edge.
REQ-018 SHALL have latency of exactly 2 cycles from input transfer to out_valid when there is no stall.
REQ-019 SHALL sustain 1 beat per cycle when out_ready is held high.
REQ-020 SHALL move S2 when it is empty or its beat is leaving: s2_adv = !s2_valid | out_ready.
REQ-021 SHALL drive in_ready = !s1_valid | s2_adv combinationally, with no dependence on in_valid.
REQ-022 SHALL hold out_data, out_inv and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL hold S1 contents under stall; a full pipeline SHALL buffer exactly 2 beats.
REQ-024 SHALL NOT drop, duplicate or reorder beats under any in_valid/out_ready pattern.
REQ-025 SHALL, when an input and an output transfer occur in the same cycle on a full pipe, shift all beats one stage.
REQ-026 SHALL drive out_data and out_inv as don't-care when out_valid=0.
REQ-027 SHALL increment beat_cnt by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-028 SHALL apply in_inv per beat, so mixed-mode back-to-back beats are each mapped with their own mode.

Reset
REQ-029 SHALL, while rst=1: clear s1_valid, s2_valid and out_valid to 0, clear beat_cnt to 0, and force in_ready to 1 from the first clock edge after rst deasserts.
REQ-030 SHALL discard any in-flight beats when rst is asserted mid-operation; no partial beat is emitted after reset.
REQ-031 SHALL clear data registers to 0 on reset; their value is not observable while out_valid=0.

Verification
REQ-032 SHALL cover: LANES=4, forward, in_data=0xFF53_0100, out_ready=1 -> 2 cycles later out_data=0x16ED_7C63, out_inv=0, beat_cnt=1.
REQ-033 SHALL cover: inverse, in_data=0x16ED_7C63 -> out_data=0xFF53_0100, out_inv=1; a following forward beat of 0x0000_0000 -> 0x6363_6363, then 0x0052_0052 -> 0x6300_6300.
REQ-034 SHALL cover: out_ready=0 with 3 beats offered -> in_ready=0 after 2 accepted, out_data held stable; out_ready=1 -> beats emerge in order at 1 per cycle.
REQ-035 SHALL cover: random in_valid/out_ready over 10k beats, all 256 values, both modes, scoreboarded against a table model -> zero mismatches, beat_cnt equal to delivered count mod 65536.
REQ-036 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0 immediately (asynchronous), beat_cnt=0, and no stale beat emitted after release.
REQ-037 SHALL cover: INV_EN=0 with in_inv=1 and in_data byte 0x63 -> out byte 0xFB (forward), out_inv=0; and LANES=1 with input 0x00 -> output 0x63.

Source files
------------

// File: rtl/subbytes_engine.sv
// AES SubBytes engine: LANES independent byte S-box lookups per beat behind a
// two-stage valid/ready pipeline (S1 = operand register, S2 = result register).
module subbytes_engine #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned INV_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inv,
    output logic [8*LANES-1:0]   out_data,
    output logic [15:0]          beat_cnt
);

    localparam int unsigned W = 8 * LANES;

    // GF(2^8) arithmetic over the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    endfunction

    // One shared field inversion per lane; the affine steps sit on either side
    // of it depending on direction.
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] pre;
        logic [7:0] y;
        pre = inv ? affine_inv(x) : x;
        y   = gf_inv(pre);
        return inv ? y : affine_fwd(y);
    endfunction

    logic           s1_valid;
    logic           s1_inv;
    logic [W-1:0]   s1_data;
    logic           s2_valid;
    logic           s2_inv;
    logic [W-1:0]   s2_data;
    logic [W-1:0]   sub_data;
    logic           s2_adv;
    logic           mode_in;

    if (INV_EN != 0) begin : g_mode_sel
        assign mode_in = in_inv;
    end else begin : g_mode_fwd
        assign mode_in = 1'b0;
    end

    assign s2_adv   = !s2_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        if (INV_EN != 0) begin : g_both
            assign sub_data[8*i +: 8] = sbox(s1_data[8*i +: 8], s1_inv);
        end else begin : g_fwd_only
            assign sub_data[8*i +: 8] = affine_fwd(gf_inv(s1_data[8*i +: 8]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inv   <= 1'b0;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_inv  <= mode_in;
                s1_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_inv   <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inv  <= s1_inv;
                s2_data <= sub_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 16'h0000;
        end else if (s2_valid && out_ready) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

    assign out_valid = s2_valid;
    assign out_inv   = s2_inv;
    assign out_data  = s2_data;

endmodule
